csr_access_ctrl: RTL and testbench

- Multi-cycle sequencer that drives the CSR register file's read/write/ecall interface on behalf of the execute stage.
- Accepts one CSR-class instruction per valid/ready handshake: CSRRW, CSRRS, CSRRC, ECALL or MRET.
- Performs the read-modify-write or trap sequence against the CSR file, then returns the old CSR value and any PC redirect to writeback/branch logic.

---
 rtl/csr_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: runs CSRRW/CSRRS/CSRRC read-modify-write and ECALL/MRET trap steps against the CSR file.
// Latency accept->rsp_valid: 2 cycles (no write) / 3 cycles (write); holds one request, req_ready low until response taken.
module csr_access_ctrl #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [CSR_AW-1:0] req_csr,
  input  logic [XLEN-1:0]   req_src,
  input  logic [XLEN-1:0]   req_pc,
  output logic [CSR_AW-1:0] csr_rd_reg,
  input  logic [XLEN-1:0]   csr_rd_bus,
  output logic              csr_wr_en,
  output logic              csr_wr_set,
  output logic [CSR_AW-1:0] csr_wr_reg,
  output logic [XLEN-1:0]   csr_wr_bus,
  output logic              csr_ecall,
  output logic [XLEN-1:0]   csr_pc,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_redirect,
  output logic [XLEN-1:0]   rsp_target,
  output logic              rsp_illegal
);

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_op;
  logic [CSR_AW-1:0] r_csr;
  logic [XLEN-1:0]   r_src;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_target;
  logic              r_redirect;
  logic              r_illegal;

  logic              w_accept;
  logic              w_rmw_op;
  logic              w_csr_impl;
  logic              w_need_write;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_rmw_op   = (r_op == OP_CSRRW) || (r_op == OP_CSRRS) || (r_op == OP_CSRRC);
  assign w_csr_impl = (r_csr == A_MSTATUS) || (r_csr == A_MTVEC) ||
                      (r_csr == A_MEPC)    || (r_csr == A_MCAUSE);
  // Set/clear with a zero mask is a pure read, so no write cycle is spent.
  assign w_need_write = w_rmw_op && w_csr_impl &&
                        ((r_op == OP_CSRRW) || (r_src != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next_state = S_READ;
      S_READ:  w_next_state = w_need_write ? S_WRITE : S_RESP;
      S_WRITE: w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= '0;
      r_csr      <= '0;
      r_src      <= '0;
      r_pc       <= '0;
      r_old      <= '0;
      r_target   <= '0;
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_op       <= req_op;
      r_csr      <= req_csr;
      r_src      <= req_src;
      r_pc       <= req_pc;
      r_old      <= '0;
      r_target   <= '0;
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (r_state == S_READ) begin
      r_old <= csr_rd_bus;
      case (r_op)
        OP_CSRRW, OP_CSRRS, OP_CSRRC: r_illegal <= !w_csr_impl;
        OP_ECALL: begin
          r_target   <= csr_mtvec;
          r_redirect <= 1'b1;
        end
        OP_MRET: begin
          r_target   <= csr_mepc;
          r_redirect <= 1'b1;
        end
        default: r_illegal <= 1'b1;
      endcase
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    csr_rd_reg   = '0;
    csr_wr_en    = 1'b0;
    csr_wr_set   = 1'b0;
    csr_wr_reg   = '0;
    csr_wr_bus   = '0;
    csr_ecall    = 1'b0;
    csr_pc       = '0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_redirect = 1'b0;
    rsp_target   = '0;
    rsp_illegal  = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        csr_rd_reg = r_csr;
        if (r_op == OP_ECALL) begin
          csr_ecall = 1'b1;
          csr_pc    = r_pc;
        end
      end
      S_WRITE: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = r_csr;
        // The CSR file only overwrites or ORs, so clear is resolved here from the read value.
        case (r_op)
          OP_CSRRS: begin
            csr_wr_set = 1'b1;
            csr_wr_bus = r_src;
          end
          OP_CSRRC: csr_wr_bus = r_old & ~r_src;
          default:  csr_wr_bus = r_src;
        endcase
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        rsp_rdata    = w_rmw_op ? r_old : '0;
        rsp_redirect = r_redirect;
        rsp_target   = r_redirect ? r_target : '0;
        rsp_illegal  = r_illegal;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a small behavioural CSR file attached.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_src = '0;
  logic [31:0] req_pc = '0;
  logic [11:0] csr_rd_reg;
  logic [31:0] csr_rd_bus;
  logic        csr_wr_en;
  logic        csr_wr_set;
  logic [11:0] csr_wr_reg;
  logic [31:0] csr_wr_bus;
  logic        csr_ecall;
  logic [31:0] csr_pc;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_redirect;
  logic [31:0] rsp_target;
  logic        rsp_illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mstatus = '0;
  logic [31:0] m_mtvec = '0;
  logic [31:0] m_mepc = '0;
  logic [31:0] m_mcause = '0;
  int          wr_cnt = 0;
  int          ecall_cnt = 0;
  logic [31:0] last_wr_bus = '0;
  logic        last_wr_set = 1'b0;
  logic [31:0] last_ecall_pc = '0;

  always #5 clk = ~clk;

  csr_access_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_src(req_src), .req_pc(req_pc),
    .csr_rd_reg(csr_rd_reg), .csr_rd_bus(csr_rd_bus),
    .csr_wr_en(csr_wr_en), .csr_wr_set(csr_wr_set),
    .csr_wr_reg(csr_wr_reg), .csr_wr_bus(csr_wr_bus),
    .csr_ecall(csr_ecall), .csr_pc(csr_pc),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
  );

  // Behavioural CSR file: combinational read, OR/overwrite writes, mepc capture on trap entry.
  always_comb begin
    case (csr_rd_reg)
      12'h300: csr_rd_bus = m_mstatus;
      12'h305: csr_rd_bus = m_mtvec;
      12'h341: csr_rd_bus = m_mepc;
      12'h342: csr_rd_bus = m_mcause;
      default: csr_rd_bus = 32'hDEADBEEF;
    endcase
  end
  assign csr_mtvec = m_mtvec;
  assign csr_mepc  = m_mepc;

  always @(posedge clk) begin
    if (csr_wr_en) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_bus <= csr_wr_bus;
      last_wr_set <= csr_wr_set;
      case (csr_wr_reg)
        12'h300: m_mstatus <= csr_wr_set ? (m_mstatus | csr_wr_bus) : csr_wr_bus;
        12'h305: m_mtvec   <= csr_wr_set ? (m_mtvec   | csr_wr_bus) : csr_wr_bus;
        12'h341: m_mepc    <= csr_wr_set ? (m_mepc    | csr_wr_bus) : csr_wr_bus;
        12'h342: m_mcause  <= csr_wr_set ? (m_mcause  | csr_wr_bus) : csr_wr_bus;
        default: ;
      endcase
    end
    if (csr_ecall) begin
      ecall_cnt     <= ecall_cnt + 1;
      last_ecall_pc <= csr_pc;
      m_mepc        <= csr_pc;
    end
  end

  // Issues one request and returns once rsp_valid is seen; lat counts edges from the accept edge.
  task automatic start_req(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                           input logic [31:0] pc, input logic rr, output int lat);
    req_op    = op;
    req_csr   = csr;
    req_src   = src;
    req_pc    = pc;
    rsp_ready = rr;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    lat++;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_wr_en !== 1'b0 || csr_ecall !== 1'b0 ||
        csr_rd_reg !== 12'h0 || rsp_rdata !== 32'h0 || rsp_redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b wr_en=%b ecall=%b rd_reg=%h rdata=%h redir=%b, required 1 0 0 0 000 0 0",
               req_ready, rsp_valid, csr_wr_en, csr_ecall, csr_rd_reg, rsp_rdata, rsp_redirect);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_csrrw();
    int lat;
    int w0;
    w0 = wr_cnt;
    start_req(3'd0, 12'h305, 32'h80000100, 32'h0, 1'b1, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL csrrw_latency: got %0d, required 3", lat);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_illegal !== 1'b0 || rsp_redirect !== 1'b0) begin
      errors++;
      $display("FAIL csrrw_rsp: rdata=%h ill=%b redir=%b, required 0 0 0", rsp_rdata, rsp_illegal, rsp_redirect);
    end
    finish_rsp();
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_set !== 1'b0 || last_wr_bus !== 32'h80000100) begin
      errors++;
      $display("FAIL csrrw_write: pulses=%0d set=%b bus=%h, required 1 0 80000100", wr_cnt - w0, last_wr_set, last_wr_bus);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL csrrw_idle: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_set_clear();
    int lat;
    start_req(3'd0, 12'h300, 32'h1800, 32'h0, 1'b0, lat);
    finish_rsp();
    start_req(3'd2, 12'h300, 32'h800, 32'h0, 1'b0, lat);
    checks++;
    if (rsp_rdata !== 32'h1800) begin
      errors++;
      $display("FAIL csrrc_rdata: got %h, required 00001800", rsp_rdata);
    end
    finish_rsp();
    checks++;
    if (last_wr_bus !== 32'h1000 || last_wr_set !== 1'b0 || m_mstatus !== 32'h1000) begin
      errors++;
      $display("FAIL csrrc_write: bus=%h set=%b mstatus=%h, required 00001000 0 00001000", last_wr_bus, last_wr_set, m_mstatus);
    end
    start_req(3'd1, 12'h300, 32'h1, 32'h0, 1'b0, lat);
    checks++;
    if (rsp_rdata !== 32'h1000 || lat != 3) begin
      errors++;
      $display("FAIL csrrs_rsp: rdata=%h lat=%0d, required 00001000 3", rsp_rdata, lat);
    end
    finish_rsp();
    checks++;
    if (last_wr_bus !== 32'h1 || last_wr_set !== 1'b1 || m_mstatus !== 32'h1001) begin
      errors++;
      $display("FAIL csrrs_write: bus=%h set=%b mstatus=%h, required 00000001 1 00001001", last_wr_bus, last_wr_set, m_mstatus);
    end
  endtask

  task automatic test_read_only();
    int lat;
    int w0;
    start_req(3'd0, 12'h342, 32'hB, 32'h0, 1'b0, lat);
    finish_rsp();
    w0 = wr_cnt;
    start_req(3'd1, 12'h342, 32'h0, 32'h0, 1'b0, lat);
    checks++;
    if (lat != 2 || rsp_rdata !== 32'hB) begin
      errors++;
      $display("FAIL csrrs_zero_rsp: lat=%0d rdata=%h, required 2 0000000b", lat, rsp_rdata);
    end
    finish_rsp();
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL csrrs_zero_nowrite: pulses=%0d, required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_trap();
    int lat;
    int w0;
    int e0;
    start_req(3'd0, 12'h305, 32'h80000200, 32'h0, 1'b0, lat);
    checks++;
    if (rsp_rdata !== 32'h80000100) begin
      errors++;
      $display("FAIL mtvec_old: got %h, required 80000100", rsp_rdata);
    end
    finish_rsp();
    w0 = wr_cnt;
    e0 = ecall_cnt;
    start_req(3'd3, 12'h000, 32'h0, 32'h80000044, 1'b0, lat);
    checks++;
    if (lat != 2 || rsp_redirect !== 1'b1 || rsp_target !== 32'h80000200 || rsp_rdata !== 32'h0 || rsp_illegal !== 1'b0) begin
      errors++;
      $display("FAIL ecall_rsp: lat=%0d redir=%b target=%h rdata=%h ill=%b, required 2 1 80000200 0 0",
               lat, rsp_redirect, rsp_target, rsp_rdata, rsp_illegal);
    end
    finish_rsp();
    checks++;
    if (ecall_cnt - e0 != 1 || last_ecall_pc !== 32'h80000044 || wr_cnt != w0) begin
      errors++;
      $display("FAIL ecall_pulse: pulses=%0d pc=%h writes=%0d, required 1 80000044 0", ecall_cnt - e0, last_ecall_pc, wr_cnt - w0);
    end
    start_req(3'd4, 12'h000, 32'h0, 32'h0, 1'b0, lat);
    checks++;
    if (rsp_redirect !== 1'b1 || rsp_target !== 32'h80000044 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mret_rsp: redir=%b target=%h rdata=%h, required 1 80000044 0", rsp_redirect, rsp_target, rsp_rdata);
    end
    finish_rsp();
    checks++;
    if (ecall_cnt - e0 != 1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL mret_side_effects: ecalls=%0d writes=%0d, required 1 0", ecall_cnt - e0, wr_cnt - w0);
    end
  endtask

  task automatic test_illegal();
    int lat;
    int w0;
    w0 = wr_cnt;
    start_req(3'd0, 12'h7C0, 32'h5, 32'h0, 1'b0, lat);
    checks++;
    if (lat != 2 || rsp_illegal !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_redirect !== 1'b0) begin
      errors++;
      $display("FAIL bad_csr_rsp: lat=%0d ill=%b rdata=%h redir=%b, required 2 1 deadbeef 0", lat, rsp_illegal, rsp_rdata, rsp_redirect);
    end
    finish_rsp();
    start_req(3'd6, 12'h300, 32'h7, 32'h0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_rdata !== 32'h0 || rsp_target !== 32'h0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b ill=%b rdata=%h target=%h req_ready=%b, required 1 1 0 0 0",
                 i, rsp_valid, rsp_illegal, rsp_rdata, rsp_target, req_ready);
      end
      @(posedge clk);
      #1;
    end
    finish_rsp();
    checks++;
    if (wr_cnt != w0 || m_mstatus !== 32'h1001) begin
      errors++;
      $display("FAIL illegal_nowrite: writes=%0d mstatus=%h, required 0 00001001", wr_cnt - w0, m_mstatus);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    int lat;
    w0 = wr_cnt;
    req_op    = 3'd0;
    req_csr   = 12'h341;
    req_src   = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (csr_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL write_phase: wr_en=%b, required 1", csr_wr_en);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (csr_wr_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: wr_en=%b req_ready=%b rsp_valid=%b, required 0 1 0", csr_wr_en, req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr_cnt != w0 || m_mepc !== 32'h80000044 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_dropped_write: writes=%0d mepc=%h req_ready=%b, required 0 80000044 1", wr_cnt - w0, m_mepc, req_ready);
    end
    start_req(3'd2, 12'h341, 32'h0, 32'h0, 1'b0, lat);
    checks++;
    if (rsp_rdata !== 32'h80000044 || lat != 2) begin
      errors++;
      $display("FAIL post_reset_read: rdata=%h lat=%0d, required 80000044 2", rsp_rdata, lat);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_set_clear();
    test_read_only();
    test_trap();
    test_illegal();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
